// File: rtl/vanilla_sb_clear_scheduler.sv
// vanilla_sb_clear_scheduler
// Moves scoreboard-clear / writeback requests from long-latency sources
// (remote loads, idiv, fdiv/fsqrt) onto the single int and single float
// regfile write ports. Each class has its own round-robin pointer. A
// starvation counter per class raises stall_force_o when the pipeline's own
// writebacks have held a class off for max_block_p consecutive cycles.
//
// Handshake (valid/yumi): a requester raises req_v_i and holds req_float_i,
// req_id_i and req_data_i stable until it sees req_yumi_o high in the same
// cycle. req_yumi_o is combinational from req_v_i, the block inputs and
// reset_i. It is never high for a requester whose valid is low, at most one
// requester per class sees it in a cycle, and every requester sees it low
// while reset_i is high. A yumi in cycle t produces the matching
// *_sb_clear_o pulse, id and data in cycle t+1.
//
// Class index 0 is the int port and class index 1 is the float port.
module vanilla_sb_clear_scheduler #(
  parameter int num_req_p        = 4,
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5,
  parameter int max_block_p      = 4
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  input  logic [num_req_p-1:0]                  req_float_i,
  input  logic [num_req_p*reg_addr_width_p-1:0] req_id_i,
  input  logic [num_req_p*data_width_p-1:0]     req_data_i,
  output logic [num_req_p-1:0]                  req_yumi_o,
  input  logic                                  int_block_i,
  input  logic                                  float_block_i,
  output logic                                  int_sb_clear_o,
  output logic [reg_addr_width_p-1:0]           int_sb_clear_id_o,
  output logic [data_width_p-1:0]               int_wb_data_o,
  output logic                                  float_sb_clear_o,
  output logic [reg_addr_width_p-1:0]           float_sb_clear_id_o,
  output logic [data_width_p-1:0]               float_wb_data_o,
  output logic                                  stall_force_o
);

  localparam int ptr_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cnt_w_lp = $clog2(max_block_p + 1);
  localparam logic [ptr_w_lp-1:0] ptr_max_lp = ptr_w_lp'(num_req_p - 1);
  localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(max_block_p);

  // Per-class combinational signals.
  logic [1:0]                       blk;
  logic [1:0][num_req_p-1:0]        elig;
  logic [1:0]                       grant;
  logic [1:0][ptr_w_lp-1:0]         pick;
  logic [1:0][reg_addr_width_p-1:0] sel_id;
  logic [1:0][data_width_p-1:0]     sel_data;
  logic [1:0][cnt_w_lp-1:0]         cnt_n;

  // Per-class state.
  logic [1:0][ptr_w_lp-1:0]         last_q;
  logic [1:0][cnt_w_lp-1:0]         cnt_q;
  logic [1:0]                       clear_q;
  logic [1:0][reg_addr_width_p-1:0] id_q;
  logic [1:0][data_width_p-1:0]     data_q;
  logic                             stall_q;

  assign blk[0] = int_block_i;
  assign blk[1] = float_block_i;

  // Round-robin search per class: scan from last_grant+1 around the ring
  // and take the first eligible requester. No grant while the port is
  // blocked or the block is in reset.
  always_comb begin : arb_comb
    logic [ptr_w_lp-1:0] idx;
    elig  = '0;
    grant = '0;
    pick  = '0;
    idx   = '0;
    for (int c = 0; c < 2; c++) begin
      elig[c] = req_v_i & ((c == 1) ? req_float_i : ~req_float_i);
      idx = (last_q[c] == ptr_max_lp) ? '0 : last_q[c] + 1'b1;
      for (int i = 0; i < num_req_p; i++) begin
        if (!grant[c] && !reset_i && !blk[c] && elig[c][idx]) begin
          grant[c] = 1'b1;
          pick[c]  = idx;
        end
        idx = (idx == ptr_max_lp) ? '0 : idx + 1'b1;
      end
    end
  end

  // Yumi back to the winners; the two classes never pick the same requester
  // because their eligibility masks are disjoint on req_float_i.
  always_comb begin
    req_yumi_o = '0;
    for (int c = 0; c < 2; c++) begin
      if (grant[c]) begin
        req_yumi_o[pick[c]] = 1'b1;
      end
    end
  end

  // Route the winning requester's id and data toward the output registers.
  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < num_req_p; i++) begin
        if (pick[c] == ptr_w_lp'(i)) begin
          sel_id[c]   = req_id_i[i*reg_addr_width_p +: reg_addr_width_p];
          sel_data[c] = req_data_i[i*data_width_p +: data_width_p];
        end
      end
    end
  end

  // Starvation counters: count consecutive blocked cycles that have work
  // waiting, saturate at max_block_p, drop to zero on a grant or idle class.
  // While the pipeline keeps blocking past saturation the count holds.
  always_comb begin
    cnt_n = cnt_q;
    for (int c = 0; c < 2; c++) begin
      if (grant[c] || (elig[c] == '0)) begin
        cnt_n[c] = '0;
      end else if (blk[c] && (cnt_q[c] != cnt_max_lp)) begin
        cnt_n[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  // Pointer, counter and output registers. Stall is derived from the next
  // counter values so it rises in the cycle right after the saturating
  // blocked cycle and falls in the cycle right after the releasing grant.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q  <= {2{ptr_max_lp}};
      cnt_q   <= '0;
      clear_q <= '0;
      id_q    <= '0;
      data_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        clear_q[c] <= grant[c];
        if (grant[c]) begin
          last_q[c] <= pick[c];
          id_q[c]   <= sel_id[c];
          data_q[c] <= sel_data[c];
        end
      end
      cnt_q   <= cnt_n;
      stall_q <= (cnt_n[0] == cnt_max_lp) | (cnt_n[1] == cnt_max_lp);
    end
  end

  assign int_sb_clear_o      = clear_q[0];
  assign int_sb_clear_id_o   = id_q[0];
  assign int_wb_data_o       = data_q[0];
  assign float_sb_clear_o    = clear_q[1];
  assign float_sb_clear_id_o = id_q[1];
  assign float_wb_data_o     = data_q[1];
  assign stall_force_o       = stall_q;

endmodule

// File: tb/tb_vanilla_sb_clear_scheduler.sv
// Bench for vanilla_sb_clear_scheduler: directed scenarios followed by a
// long randomized run, all checked against a cycle-level reference model
// that arbitrates by scanning (last+k) % N over a plain requester table.
module tb_vanilla_sb_clear_scheduler;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int MAX   = 4;
  localparam int BOUND = N * (MAX + 2);
  localparam int W     = RW + DW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_i;
  logic [N-1:0]      req_v, req_float, req_yumi;
  logic [N*RW-1:0]   req_id;
  logic [N*DW-1:0]   req_data;
  logic              int_block, float_block;
  logic              int_clr, float_clr, stall_force;
  logic [RW-1:0]     int_id, float_id;
  logic [DW-1:0]     int_data, float_data;

  vanilla_sb_clear_scheduler #(
    .num_req_p(N), .data_width_p(DW), .reg_addr_width_p(RW), .max_block_p(MAX)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_v_i(req_v), .req_float_i(req_float), .req_id_i(req_id), .req_data_i(req_data),
    .req_yumi_o(req_yumi),
    .int_block_i(int_block), .float_block_i(float_block),
    .int_sb_clear_o(int_clr), .int_sb_clear_id_o(int_id), .int_wb_data_o(int_data),
    .float_sb_clear_o(float_clr), .float_sb_clear_id_o(float_id), .float_wb_data_o(float_data),
    .stall_force_o(stall_force)
  );

  // requester table
  bit            rv[N];
  bit            rf[N];
  logic [RW-1:0] rid[N];
  logic [DW-1:0] rdata[N];
  int            age[N];

  // reference model
  int  m_last[2];
  int  m_cnt[2];
  bit  m_clr[2];
  bit  m_stall;
  logic [W-1:0] exp_q_int[$];
  logic [W-1:0] exp_q_float[$];

  int  n_cmp, n_err;
  bit  persist, auto_req, obey_stall;
  logic [N-1:0] seen_yumi;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_v[i]              = rv[i];
      req_float[i]          = rf[i];
      req_id[i*RW +: RW]    = rid[i];
      req_data[i*DW +: DW]  = rdata[i];
    end
  endtask

  task automatic set_req(input int i, input bit f, input logic [RW-1:0] id, input logic [DW-1:0] d);
    rv[i] = 1'b1; rf[i] = f; rid[i] = id; rdata[i] = d; age[i] = 0;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
  endtask

  // One clock cycle: drive, check at negedge, advance model, return at posedge+1.
  task automatic run_cycle(input bit rst, input bit bi, input bit bf);
    bit           blk[2];
    bit           gnt[2];
    int           win[2];
    bit           any;
    int           j;
    logic [N-1:0] exp_yumi;
    logic [W-1:0] e;
    blk[0] = bi & ~(obey_stall & m_stall);
    blk[1] = bf & ~(obey_stall & m_stall);
    reset_i = rst; int_block = blk[0]; float_block = blk[1];
    drive_reqs();
    @(negedge clk);
    exp_yumi = '0;
    for (int c = 0; c < 2; c++) begin
      gnt[c] = 1'b0; win[c] = 0;
      if (!rst && !blk[c]) begin
        for (int k = 1; k <= N; k++) begin
          j = (m_last[c] + k) % N;
          if (!gnt[c] && rv[j] && (int'(rf[j]) == c)) begin
            gnt[c] = 1'b1; win[c] = j;
          end
        end
      end
      if (gnt[c]) exp_yumi[win[c]] = 1'b1;
    end
    seen_yumi = req_yumi;
    check("yumi", 64'(req_yumi), 64'(exp_yumi));
    check("int_clr", 64'(int_clr), 64'(m_clr[0]));
    check("flt_clr", 64'(float_clr), 64'(m_clr[1]));
    if (m_clr[0] && exp_q_int.size() > 0) begin
      e = exp_q_int.pop_front();
      check("int_id", 64'(int_id), 64'(e[W-1:DW]));
      check("int_data", 64'(int_data), 64'(e[DW-1:0]));
    end
    if (m_clr[1] && exp_q_float.size() > 0) begin
      e = exp_q_float.pop_front();
      check("flt_id", 64'(float_id), 64'(e[W-1:DW]));
      check("flt_data", 64'(float_data), 64'(e[DW-1:0]));
    end
    check("stall", 64'(stall_force), 64'(m_stall));
    // advance model
    for (int c = 0; c < 2; c++) begin
      any = 1'b0;
      for (int i = 0; i < N; i++) if (rv[i] && (int'(rf[i]) == c)) any = 1'b1;
      if (rst || gnt[c] || !any) m_cnt[c] = 0;
      else if (blk[c])           m_cnt[c] = (m_cnt[c] + 1 > MAX) ? MAX : m_cnt[c] + 1;
      m_clr[c] = !rst && gnt[c];
      if (rst) m_last[c] = N - 1;
      if (gnt[c]) begin
        m_last[c] = win[c];
        if (c == 0) exp_q_int.push_back({rid[win[c]], rdata[win[c]]});
        else        exp_q_float.push_back({rid[win[c]], rdata[win[c]]});
        check("latency", 64'(age[win[c]] <= BOUND), 64'(1));
        age[win[c]] = 0;
        if (!persist) rv[win[c]] = 1'b0;
      end
    end
    m_stall = !rst && ((m_cnt[0] == MAX) || (m_cnt[1] == MAX));
    for (int i = 0; i < N; i++) begin
      if (rv[i] && !(gnt[0] && win[0] == i) && !(gnt[1] && win[1] == i))
        age[i] = rst ? 0 : age[i] + 1;
      if (auto_req && !rv[i] && ($urandom_range(0, 9) < 4))
        set_req(i, 1'($urandom_range(0, 1)), RW'($urandom), $urandom);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    persist = 1'b0; auto_req = 1'b0; obey_stall = 1'b1;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0; rf[i] = 1'b0; rid[i] = '0; rdata[i] = '0; age[i] = 0;
    end
    for (int c = 0; c < 2; c++) begin
      m_last[c] = N - 1; m_cnt[c] = 0; m_clr[c] = 1'b0;
    end
    m_stall = 1'b0;
    reset_i = 1'b1; int_block = 1'b0; float_block = 1'b0;
    drive_reqs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_int_clr", 64'(int_clr), 64'(0));
    check("rst_flt_clr", 64'(float_clr), 64'(0));
    check("rst_stall", 64'(stall_force), 64'(0));
    check("rst_yumi", 64'(req_yumi), 64'(0));

    // 1: single int request
    set_req(0, 1'b0, 5'd5, 32'hAB);
    run_cycle(1'b0, 1'b0, 1'b0);
    check("t1_yumi", 64'(seen_yumi), 64'(4'b0001));
    check("t1_clr", 64'(int_clr), 64'(1));
    check("t1_id", 64'(int_id), 64'(5));
    check("t1_data", 64'(int_data), 64'(32'hAB));
    run_cycle(1'b0, 1'b0, 1'b0);

    // 2: all four int, held -> 0,1,2,3,0
    run_cycle(1'b1, 1'b0, 1'b0);
    persist = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, RW'(i + 1), 32'h100 + i);
    for (int k = 0; k < 5; k++) begin
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t2_order", 64'(seen_yumi), 64'(4'b0001 << (k % 4)));
      check("t2_flt_idle", 64'(float_clr), 64'(0));
    end
    persist = 1'b0;
    clear_reqs();
    run_cycle(1'b0, 1'b0, 1'b0);

    // 3: simultaneous int and float
    set_req(1, 1'b0, 5'd9, 32'h1111);
    set_req(2, 1'b1, 5'd9, 32'h2222);
    run_cycle(1'b0, 1'b0, 1'b0);
    check("t3_yumi", 64'(seen_yumi), 64'(4'b0110));
    check("t3_int_clr", 64'(int_clr), 64'(1));
    check("t3_flt_clr", 64'(float_clr), 64'(1));
    check("t3_flt_data", 64'(float_data), 64'(32'h2222));
    run_cycle(1'b0, 1'b0, 1'b0);

    // 4: starvation -> stall, then release
    set_req(0, 1'b0, 5'd3, 32'h33);
    for (int k = 0; k < MAX; k++) begin
      check("t4_no_stall", 64'(stall_force), 64'(0));
      run_cycle(1'b0, 1'b1, 1'b0);
    end
    check("t4_stall", 64'(stall_force), 64'(1));
    run_cycle(1'b0, 1'b1, 1'b0);
    check("t4_grant", 64'(seen_yumi), 64'(4'b0001));
    check("t4_stall_drop", 64'(stall_force), 64'(0));
    check("t4_clr", 64'(int_clr), 64'(1));
    run_cycle(1'b0, 1'b0, 1'b0);

    // 4b: block ignores the stall -> counter holds, stall stays high
    obey_stall = 1'b0;
    set_req(3, 1'b1, 5'd7, 32'h77);
    for (int k = 0; k < MAX + 3; k++) run_cycle(1'b0, 1'b0, 1'b1);
    check("t4b_stall_hold", 64'(stall_force), 64'(1));
    check("t4b_no_yumi", 64'(seen_yumi), 64'(0));
    obey_stall = 1'b1;
    run_cycle(1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0);

    // 5: grant req2, then reset with req0/req3 pending
    set_req(2, 1'b0, 5'd2, 32'h22);
    run_cycle(1'b0, 1'b0, 1'b0);
    check("t5_grant2", 64'(seen_yumi), 64'(4'b0100));
    set_req(0, 1'b0, 5'd10, 32'hA0);
    set_req(3, 1'b0, 5'd13, 32'hA3);
    run_cycle(1'b1, 1'b0, 1'b0);
    check("t5_rst_yumi", 64'(seen_yumi), 64'(0));
    check("t5_rst_clr", 64'(int_clr), 64'(0));
    check("t5_rst_stall", 64'(stall_force), 64'(0));
    run_cycle(1'b0, 1'b0, 1'b0);
    check("t5_first", 64'(seen_yumi), 64'(4'b0001));
    for (int k = 0; k < 3; k++) run_cycle(1'b0, 1'b0, 1'b0);

    // 6: random traffic
    auto_req = 1'b1;
    for (int k = 0; k < 10000; k++)
      run_cycle(($urandom_range(0, 399) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    auto_req = 1'b0;
    for (int k = 0; k < 4 * N; k++) run_cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) check("drained", 64'(rv[i]), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
